// File: rtl/mss_pkg.sv
// Shared types and helpers for the MSS sine voice scheduler.
package mss_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } sched_state_t;

    localparam int COUNT_SIZE_DEF = 8;
    localparam int ROM_LAST       = 2**COUNT_SIZE_DEF - 1;

    // log2 of a power-of-two voice count; doubles as the mix scale shift
    function automatic int mix_shift(input int n);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << s) < n) s++;
        end
        return s;
    endfunction

endpackage

// File: rtl/voice_phase_acc.sv
// Per-voice phase accumulator with sine ROM address extraction.
module voice_phase_acc
    import mss_pkg::*;
#(
    parameter int COUNT_SIZE = COUNT_SIZE_DEF,
    parameter int PHASE_W    = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  upd_i,
    input  logic                  en_i,
    input  logic [PHASE_W-1:0]    step_i,
    output logic [COUNT_SIZE-1:0] addr_o
);

    logic [PHASE_W-1:0]    phase_q;
    logic [PHASE_W-1:0]    phase_d;
    logic [COUNT_SIZE-1:0] top_w;

    always_comb begin
        phase_d = phase_q;
        if (upd_i) begin
            phase_d = en_i ? phase_q + step_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // The ROM lacks its all-ones entry, so that address folds onto 0
    assign top_w  = phase_q[PHASE_W-1 -: COUNT_SIZE];
    assign addr_o = (&top_w) ? '0 : top_w;

endmodule

// File: rtl/sin_voice_sched.sv
// Time-multiplexes one registered sine ROM across several tone voices
// and mixes their samples into one scaled output sample per tick.
module sin_voice_sched
    import mss_pkg::*;
#(
    parameter int COUNT_SIZE = $clog2(ROM_LAST + 1),
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 20
) (
    input  logic                               CLK,
    input  logic                               RESETn,
    input  logic                               sample_tick,
    input  logic [NUM_VOICES-1:0]              voice_en,
    input  logic [NUM_VOICES-1:0][PHASE_W-1:0] freq_step,
    output logic [COUNT_SIZE-1:0]              rom_addr,
    input  logic [15:0]                        rom_q,
    output logic [15:0]                        sample_out,
    output logic                               sample_valid,
    output logic                               busy,
    output logic                               overrun
);

    localparam int SH = mix_shift(NUM_VOICES);
    localparam int SW = (NUM_VOICES > 1) ? SH : 1;
    localparam int AW = 16 + SH;

    sched_state_t          state_q;
    logic [SW-1:0]         slot_q;
    logic [SW-1:0]         slot_nxt;
    logic [AW-1:0]         acc_q;
    logic [AW-1:0]         add_w;
    logic [AW-1:0]         sum_w;
    logic                  den_q;
    logic [NUM_VOICES-1:0] upd_w;
    logic [COUNT_SIZE-1:0] addr_w [NUM_VOICES];

    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
        assign upd_w[k] = (state_q == ISSUE) && (32'(slot_q) == k);

        voice_phase_acc #(
            .COUNT_SIZE(COUNT_SIZE),
            .PHASE_W   (PHASE_W)
        ) u_acc (
            .clk_i (CLK),
            .rst_ni(RESETn),
            .upd_i (upd_w[k]),
            .en_i  (voice_en[k]),
            .step_i(freq_step[k]),
            .addr_o(addr_w[k])
        );
    end

    assign slot_nxt = slot_q + SW'(1);
    // den_q tracks the enable of the voice whose ROM data is arriving now
    assign add_w    = den_q ? AW'($signed(rom_q)) : '0;
    assign sum_w    = acc_q + add_w;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            acc_q        <= '0;
            den_q        <= 1'b0;
            rom_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_tick && state_q != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        acc_q    <= '0;
                        slot_q   <= '0;
                        rom_addr <= addr_w[0];
                        busy     <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    den_q <= voice_en[slot_q];
                    if (slot_q != '0) begin
                        acc_q <= sum_w;
                    end
                    if (32'(slot_q) == NUM_VOICES - 1) begin
                        state_q <= DRAIN;
                    end else begin
                        slot_q   <= slot_nxt;
                        rom_addr <= addr_w[slot_nxt];
                    end
                end
                DRAIN: begin
                    acc_q        <= sum_w;
                    sample_out   <= sum_w[SH +: 16];
                    sample_valid <= 1'b1;
                    state_q      <= OUT;
                end
                OUT: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sin_voice_sched.sv
// Directed self-checking bench for sin_voice_sched with a registered
// sine ROM model holding the few entries the vectors touch.
module tb_sin_voice_sched;

    logic             CLK = 1'b0;
    logic             RESETn = 1'b0;
    logic             sample_tick = 1'b0;
    logic [3:0]       voice_en = '0;
    logic [3:0][19:0] freq_step = '0;
    logic [7:0]       rom_addr;
    logic [15:0]      rom_q = '0;
    logic [15:0]      sample_out;
    logic             sample_valid;
    logic             busy;
    logic             overrun;
    logic             bad255 = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    sin_voice_sched #(
        .COUNT_SIZE(8),
        .NUM_VOICES(4),
        .PHASE_W   (20)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .sample_tick (sample_tick),
        .voice_en    (voice_en),
        .freq_step   (freq_step),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    // 16000 * sin(2*pi*a/256), rounded toward zero
    function automatic logic [15:0] rom_val(input logic [7:0] a);
        case (a)
            8'd0:    return 16'h0000;
            8'd1:    return 16'h0188;
            8'd2:    return 16'h0311;
            8'd3:    return 16'h0499;
            8'd4:    return 16'h0620;
            8'd64:   return 16'h3E80;
            8'd128:  return 16'h0000;
            8'd192:  return 16'hC180;
            default: return 16'h7777;
        endcase
    endfunction

    always @(posedge CLK) begin
        rom_q <= rom_val(rom_addr);
        if (busy && rom_addr == 8'hFF) bad255 <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESETn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic run_tick(input string tag, input logic [15:0] exp_out,
                            input logic [3:0][7:0] exp_addr);
        int          vcyc;
        int          vcnt;
        int          bcnt;
        logic [15:0] got;
        logic [7:0]  a [4];
        vcyc = 0;
        vcnt = 0;
        bcnt = 0;
        got  = 'x;
        @(negedge CLK);
        sample_tick = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            sample_tick = 1'b0;
            if (c <= 4) a[c-1] = rom_addr;
            if (busy) bcnt++;
            if (sample_valid) begin
                vcnt++;
                vcyc = c;
                got  = sample_out;
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s addr%0d", tag, i), 32'(a[i]), 32'(exp_addr[i]));
        end
        check({tag, " valid_cnt"}, vcnt, 1);
        check({tag, " valid_cyc"}, vcyc, 6);
        check({tag, " busy_cyc"}, bcnt, 6);
        check({tag, " out"}, 32'(got), 32'(exp_out));
    endtask

    initial begin
        int vcnt;

        repeat (2) @(negedge CLK);
        check("rst addr", 32'(rom_addr), 0);
        check("rst out", 32'(sample_out), 0);
        check("rst valid", 32'(sample_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst overrun", 32'(overrun), 0);
        RESETn = 1'b1;

        // all voices disabled
        freq_step = {4{20'h01000}};
        voice_en  = 4'b0000;
        run_tick("off1", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        run_tick("off2", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});

        // two voices, then voice 1 masked and re-enabled
        voice_en = 4'b0011;
        run_tick("two_a", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        run_tick("two_b", 16'h00C4, {8'd0, 8'd0, 8'd1, 8'd1});
        voice_en = 4'b0001;
        run_tick("mask_c", 16'h00C4, {8'd0, 8'd0, 8'd2, 8'd2});
        run_tick("mask_d", 16'h0126, {8'd0, 8'd0, 8'd0, 8'd3});
        voice_en = 4'b0011;
        run_tick("reen_e", 16'h0188, {8'd0, 8'd0, 8'd0, 8'd4});

        // top-address substitution and phase wrap
        do_reset();
        voice_en     = 4'b0001;
        freq_step    = '0;
        freq_step[0] = 20'hFF000;
        run_tick("wrap1", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        freq_step[0] = 20'h01000;
        run_tick("wrap255", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        run_tick("wrap0", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        run_tick("wrap1b", 16'h0062, {8'd0, 8'd0, 8'd0, 8'd1});
        check("no addr 255", 32'(bad255), 0);

        // four voices in phase: positive peak and negative peak
        do_reset();
        voice_en  = 4'b1111;
        freq_step = {4{20'h40000}};
        run_tick("all0", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        run_tick("all64", 16'h3E80, {8'h40, 8'h40, 8'h40, 8'h40});
        run_tick("all128", 16'h0000, {8'h80, 8'h80, 8'h80, 8'h80});
        run_tick("all192", 16'hC180, {8'hC0, 8'hC0, 8'hC0, 8'hC0});

        // reset during ISSUE slot 2
        run_tick("pre0", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        run_tick("pre64", 16'h3E80, {8'h40, 8'h40, 8'h40, 8'h40});
        @(negedge CLK);
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid slot2 addr", 32'(rom_addr), 32'h80);
        RESETn = 1'b0;
        #1;
        check("mid rst addr", 32'(rom_addr), 0);
        check("mid rst out", 32'(sample_out), 0);
        check("mid rst busy", 32'(busy), 0);
        check("mid rst valid", 32'(sample_valid), 0);
        @(negedge CLK);
        RESETn = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (sample_valid) vcnt++;
        end
        check("mid no valid", vcnt, 0);
        run_tick("post0", 16'h0000, {8'd0, 8'd0, 8'd0, 8'd0});
        run_tick("post64", 16'h3E80, {8'h40, 8'h40, 8'h40, 8'h40});

        // tick while busy
        do_reset();
        check("ovr clear", 32'(overrun), 0);
        voice_en     = 4'b0001;
        freq_step    = '0;
        freq_step[0] = 20'h01000;
        @(negedge CLK);
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        @(negedge CLK);
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (sample_valid) vcnt++;
            @(negedge CLK);
        end
        check("ovr valid_cnt", vcnt, 1);
        check("ovr out", 32'(sample_out), 0);
        check("ovr set", 32'(overrun), 1);
        run_tick("ovr next", 16'h0062, {8'd0, 8'd0, 8'd0, 8'd1});
        check("ovr sticky", 32'(overrun), 1);

        // tick coincident with the OUT cycle
        do_reset();
        check("out ovr clear", 32'(overrun), 0);
        @(negedge CLK);
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        repeat (5) @(negedge CLK);
        check("out cyc valid", 32'(sample_valid), 1);
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (sample_valid || busy) vcnt++;
            @(negedge CLK);
        end
        check("out tick ignored", vcnt, 0);
        check("out ovr set", 32'(overrun), 1);
        do_reset();
        check("final ovr clear", 32'(overrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
